// File: rtl/rail_unswap.sv
`default_nettype none
// ============================================================================
//  Module      : rail_unswap
//  Description : Receiving end of the two-track rail crossover. Undoes the
//                crossing of (c, d) using the sel bit that crossed them, stores
//                the restored pair (a, b) in a 2-entry FIFO with valid/ready on
//                both sides, and counts accepted swapped beats (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module rail_unswap #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             out_swapped,
    output logic [CNT_W-1:0] swap_count
);

    // Counter ceiling and increment step, sized to the counter.
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Occupancy of the buffer is the only state the block keeps.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_t;

    occ_t             r_state;
    occ_t             w_state_nxt;

    logic [WIDTH-1:0] r_a_mem [2];
    logic [WIDTH-1:0] r_b_mem [2];
    logic [1:0]       r_sel_mem;
    logic             r_wptr;
    logic             r_rptr;
    logic [CNT_W-1:0] r_swap_count;

    logic             w_push;
    logic             w_pop;
    logic             w_in_ready;
    logic             w_out_valid;
    logic [WIDTH-1:0] w_a_restored;
    logic [WIDTH-1:0] w_b_restored;

    // Ready depends only on registered occupancy; rst_n gating keeps it low
    // while reset is held and lets it rise as soon as reset is released.
    assign w_in_ready  = rst_n & (r_state != S_FULL);
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    // Undo the crossover before storage so the head is already restored.
    assign w_a_restored = sel ? d : c;
    assign w_b_restored = sel ? c : d;

    // Occupancy next-state: push/pop on the same cycle leaves it unchanged.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_push && !w_pop) begin
                    w_state_nxt = S_FULL;
                end else if (w_pop && !w_push) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_state_nxt = S_ONE;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // Occupancy register and read/write pointers (wrap modulo 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

    // One storage slot per entry, written when the write pointer selects it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        // Capture the restored pair and its sel bit on push into this slot.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a_mem[gi]   <= '0;
                r_b_mem[gi]   <= '0;
                r_sel_mem[gi] <= 1'b0;
            end else if (w_push && (r_wptr == gi[0])) begin
                r_a_mem[gi]   <= w_a_restored;
                r_b_mem[gi]   <= w_b_restored;
                r_sel_mem[gi] <= sel;
            end
        end
    end

    // Saturating count of accepted beats that arrived swapped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_swap_count <= '0;
        end else if (w_push && sel && (r_swap_count != c_cnt_max)) begin
            r_swap_count <= r_swap_count + c_cnt_one;
        end
    end

    // Head entry drives the outputs; forced to zero when the buffer is empty.
    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign a           = w_out_valid ? r_a_mem[r_rptr] : '0;
    assign b           = w_out_valid ? r_b_mem[r_rptr] : '0;
    assign out_swapped = w_out_valid ? r_sel_mem[r_rptr] : 1'b0;
    assign swap_count  = r_swap_count;

endmodule
`default_nettype wire

// File: doc/rail_unswap.md
Name: rail_unswap

Overview:
- Receiving end of the two-track rail crossover: takes the crossed pair (c, d) together with the select bit that crossed them, and restores the original pair (a, b).
- Clocked, with valid/ready handshakes on both sides.
- A 2-entry buffer decouples the upstream crossover from the downstream consumer.
- A saturating counter reports how many accepted beats arrived swapped.

Parameters:
- WIDTH, 8, bit width of each track.
- CNT_W, 16, width of swap_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat (c, d, sel) valid.
- in_ready  output  1  block can accept a beat this cycle.
- c  input  WIDTH  crossed track 0.
- d  input  WIDTH  crossed track 1.
- sel  input  1  crossover setting used for this beat (0 = straight, 1 = swapped).
- out_valid  output  1  restored pair available at buffer head.
- out_ready  input  1  downstream accepts head this cycle.
- a  output  WIDTH  restored track 0.
- b  output  WIDTH  restored track 1.
- out_swapped  output  1  sel bit of the beat at the head.
- swap_count  output  CNT_W  accepted beats with sel=1, saturating.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- While rst_n=0, all state clears: buffer empty, in_ready=0, out_valid=0, a=0, b=0, out_swapped=0, swap_count=0. Reset asserted mid-operation discards buffered beats immediately.
- The first rising edge after rst_n deasserts sees in_ready=1.
- Restore rule, applied at push time:
  - sel=0: stored a=c, b=d.
  - sel=1: stored a=d, b=c.
  - The sel bit is stored alongside the pair.
- Buffer: 2 entries, pointers wrap modulo 2, occupancy count 0..2.
  - in_ready = (count < 2); combinational from registered count only, never from out_ready.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - out_valid = (count > 0).
  - a, b, out_swapped show the head entry; all read 0 when empty.
- Latency: a beat pushed at edge N is visible at the outputs with out_valid=1 after edge N (one-cycle latency). There is no combinational pass-through.
- Simultaneous push and pop:
  - count=1: count stays 1, head advances, new entry written.
  - count=2: in_ready=0, so pop only and count becomes 1.
  - count=0: pop impossible, push only.
- in_valid while in_ready=0: ignored; upstream must hold the beat (standard valid/ready).
- Output stability: while out_valid=1 and out_ready=0, a, b and out_swapped must not change.
- swap_count:
  - Increments by 1 on each push with sel=1.
  - Holds at 2^CNT_W-1 once reached.
  - Beats with sel=0 do not affect it.
  - Pops do not affect it.
- Ordering: strict FIFO; beats leave in acceptance order.
- No internal state machine beyond the occupancy count (EMPTY/ONE/FULL = count 0/1/2):
  - EMPTY to ONE on push.
  - ONE to FULL on push without pop.
  - ONE to EMPTY on pop without push.
  - FULL to ONE on pop.

Test Plan:
- Straight pass: c=8'b10010010, d=8'b00011110, sel=0, out_ready=1 -> next cycle out_valid=1, a=8'b10010010, b=8'b00011110, out_swapped=0, swap_count=0.
- Swap restore: c=8'b11111110, d=8'b10011010, sel=1 -> a=8'b10011010, b=8'b11111110, out_swapped=1, swap_count=1.
- Backpressure fill:
  - Setup: out_ready=0; push (0x26,0xD2,sel=1) then (0x92,0x1E,sel=0).
  - Expect in_ready=0 after the second push, and a 3rd beat held off.
  - Head stays a=0xD2, b=0x26 for 5 idle cycles.
  - Raise out_ready: drains in order, then in_ready=1.
- Simultaneous push/pop at count=1: out_ready=1, in_valid=1 every cycle for 8 beats -> count stays 1, one output per cycle in order, no beat lost or duplicated.
- Saturation with CNT_W=2: 5 pushes with sel=1 -> swap_count reads 1,2,3,3,3.
- Reset mid-operation: buffer full, swap_count=2; pulse rst_n=0 between clock edges -> out_valid, a, b, swap_count go 0 immediately, without waiting for a clock edge; in_ready=1 after release; the old beats never appear.
